// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store sequencer and the instruction decoder:
//   - access-size encodings driven by the decoder on mem_data_size
//   - sequencer state enum
//   - size_bytes(): access size -> number of byte transfers
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

  localparam logic [1:0] SIZE_ILLEGAL = 2'b00;
  localparam logic [1:0] SIZE_BYTE    = 2'b01;
  localparam logic [1:0] SIZE_HALF    = 2'b10;
  localparam logic [1:0] SIZE_WORD    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FINISH
  } lsu_state_e;

  // Number of byte transfers for an access size; 0 for the illegal encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Byte-wide request/acknowledge data-memory bus.
//   bus_req   : byte transfer request (master -> memory)
//   bus_we    : 1 = write byte        (master -> memory)
//   bus_addr  : byte address          (master -> memory)
//   bus_wdata : write byte            (master -> memory)
//   bus_rdata : read byte, valid with bus_ack (memory -> master)
//   bus_ack   : byte accepted/returned, sampled on a rising edge (memory -> master)
// -----------------------------------------------------------------------------
interface load_store_unit_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load-result extension. The assembled value holds the loaded
// bytes right-aligned; byte and halfword results are sign- or zero-extended.
//   value  : assembled load value (right-aligned)
//   size   : access size encoding
//   sign   : 1 = sign-extend, 0 = zero-extend
//   result : extended 32-bit load result
// -----------------------------------------------------------------------------
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] value,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    result = value;
    case (size)
      SIZE_BYTE: result = {{24{sign & value[7]}},  value[7:0]};
      SIZE_HALF: result = {{16{sign & value[15]}}, value[15:0]};
      default:   result = value;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Executes one data-memory load or store as a sequence of big-endian byte
// transfers on a request/acknowledge bus, then extends the load result.
//   clk, reset       : clock, asynchronous active-high reset
//   start            : one-cycle request, sampled only in IDLE
//   mem_read/write   : decoder direction strobes (exactly one must be set)
//   mem_data_size    : 01 byte, 10 half, 11 word, 00 illegal
//   mem_data_sign    : 1 = sign-extend load result
//   addr, wdata      : byte address, right-aligned store data
//   rdata            : load result, held until the next successful load
//   busy, done, err  : progress, completion pulse, abort flag (valid with done)
//   bus              : byte-wide memory bus (master side)
// ACK_TIMEOUT (1..65535): non-ack cycles tolerated per byte before aborting.
// -----------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [1:0]              mem_data_size,
  input  logic                    mem_data_sign,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  load_store_unit_if.master       bus
);

  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] data_q;      // store bytes shift out of the top, load bytes shift in at the bottom
  logic [1:0]  size_q;
  logic        sign_q;
  logic        we_q;
  logic [2:0]  n_q;
  logic [1:0]  idx_q;
  logic [15:0] tmo_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        req_bad;
  logic        last_byte;
  logic        timed_out;
  logic [31:0] wdata_aligned;
  logic [31:0] load_assembled;
  logic [31:0] ext_value;

  assign req_bad = (mem_read == mem_write)
                || (mem_data_size == SIZE_ILLEGAL)
                || (mem_data_size == SIZE_HALF && addr[0])
                || (mem_data_size == SIZE_WORD && addr[1:0] != 2'b00);

  assign last_byte      = ({1'b0, idx_q} == n_q - 3'd1);
  assign timed_out      = !bus.bus_ack && (tmo_q == TMO_LAST);
  assign load_assembled = {data_q[23:0], bus.bus_rdata};

  // Left-align the sized store datum so its most significant byte is sent first.
  always_comb begin
    wdata_aligned = wdata;
    case (mem_data_size)
      SIZE_BYTE: wdata_aligned = {wdata[7:0], 24'h0};
      SIZE_HALF: wdata_aligned = {wdata[15:0], 16'h0};
      default:   wdata_aligned = wdata;
    endcase
  end

  load_extend u_load_extend (
    .value  (load_assembled),
    .size   (size_q),
    .sign   (sign_q),
    .result (ext_value)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process evaluation order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = req_bad ? FINISH : XFER;
      XFER:    if ((bus.bus_ack && last_byte) || timed_out) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request capture, byte sequencing, timeout, load result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      n_q     <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_q <= addr;
          data_q <= wdata_aligned;
          size_q <= mem_data_size;
          sign_q <= mem_data_sign;
          we_q   <= mem_write;
          n_q    <= size_bytes(mem_data_size);
          idx_q  <= '0;
          tmo_q  <= '0;
          err_q  <= req_bad;
        end
        XFER: if (bus.bus_ack) begin
          data_q <= load_assembled;
          idx_q  <= idx_q + 2'd1;
          tmo_q  <= '0;
          if (last_byte) begin
            err_q <= 1'b0;
            if (!we_q) rdata_q <= ext_value;
          end
        end else begin
          tmo_q <= tmo_q + 16'd1;
          if (timed_out) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state, so they clear with the async reset.
  always_comb begin
    busy          = (state_q != IDLE);
    done          = (state_q == FINISH);
    err           = (state_q == FINISH) && err_q;
    bus.bus_req   = (state_q == XFER);
    bus.bus_we    = (state_q == XFER) && we_q;
    bus.bus_addr  = (state_q == XFER) ? addr_q + {30'h0, idx_q} : '0;
    bus.bus_wdata = (state_q == XFER && we_q) ? data_q[31:24] : '0;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a byte memory responder, a
// transaction-level reference model (latency, error, bus byte sequence, load
// result) and a per-cycle compare process.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int T = 4;  // ACK_TIMEOUT used for the whole run

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_data_sign = 1'b0;
  logic [1:0]  mem_data_size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, err;

  load_store_unit_if bus ();

  load_store_unit #(.ACK_TIMEOUT(T)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_data_size (mem_data_size),
    .mem_data_sign (mem_data_sign),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // ---------------- memory responder ----------------
  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];
  bit  mem_loaded = 1'b0;
  int  first_wait = 0;
  bit  ack_never  = 1'b0;
  bit  ack_force  = 1'b0;
  int  byte_num, wait_cnt;

  assign bus.bus_rdata = mem[bus.bus_addr[11:0]];
  assign bus.bus_ack   = ack_force ||
                         (bus.bus_req && !ack_never && wait_cnt >= ((byte_num == 0) ? first_wait : 0));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_num <= 0;
      wait_cnt <= 0;
      if (!mem_loaded) begin
        for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
        mem_loaded <= 1'b1;
      end
    end else if (!bus.bus_req) begin
      byte_num <= 0;
      wait_cnt <= 0;
    end else if (bus.bus_ack) begin
      byte_num <= byte_num + 1;
      wait_cnt <= 0;
      if (bus.bus_we) mem[bus.bus_addr[11:0]] <= bus.bus_wdata;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [7:0]  d;
  } xfer_t;

  xfer_t       exp_q[$];
  bit          op_active = 1'b0;
  int          c0, exp_L, done_k;
  logic        exp_err;
  logic [31:0] rdata_old, rdata_new, model_rdata = '0;

  // Reference load: gather bytes big-endian, then extend from 8*n bits.
  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input logic sg);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, ref_mem[12'(a + i)]};
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // Per-cycle compare, k = cycles since the start was driven (acceptance edge ends cycle 0).
  always @(negedge clk) begin
    int    k;
    xfer_t x;
    if (op_active) begin
      k = cycle_cnt - c0;
      check("busy",    busy,        k >= 1 && k <= exp_L);
      check("done",    done,        k == exp_L);
      check("bus_req", bus.bus_req, k >= 1 && k < exp_L);
      check("rdata",   rdata,       (k >= exp_L) ? rdata_new : rdata_old);
      if (done && done_k < 0) done_k = k;
      if (k == exp_L) check("err", err, exp_err);
      if (bus.bus_req && bus.bus_ack) begin
        check("xfer_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          x = exp_q.pop_front();
          check("xfer_addr", bus.bus_addr, x.a);
          check("xfer_we",   bus.bus_we,   x.we);
          if (x.we) check("xfer_wdata", bus.bus_wdata, x.d);
        end
      end
    end
  end

  // One access: build expectations, drive start for one cycle, wait out the latency.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int fw,
                        input bit never, input bit force_ack, output int seen_k);
    int n;
    bit bad;
    n   = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : (sz == SIZE_WORD) ? 4 : 0;
    bad = (rd == wr) || (n == 0) || (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    rdata_old = model_rdata;
    rdata_new = model_rdata;
    exp_q.delete();
    if (bad) begin
      exp_L = 1; exp_err = 1'b1;
    end else if (never) begin
      exp_L = 1 + T; exp_err = 1'b1;
    end else begin
      exp_L = n + 1 + fw; exp_err = 1'b0;
      if (!wr) rdata_new = model_load(a, n, sg);
      for (int i = 0; i < n; i++) begin
        xfer_t x;
        x.a  = a + i;
        x.we = wr;
        x.d  = 8'(wd >> (8 * (n - 1 - i)));
        exp_q.push_back(x);
        if (wr) ref_mem[12'(a + i)] = x.d;
      end
    end

    @(posedge clk); #1;
    first_wait = fw; ack_never = never; ack_force = force_ack;
    mem_read = rd; mem_write = wr; mem_data_size = sz; mem_data_sign = sg;
    addr = a; wdata = wd; start = 1'b1;
    c0 = cycle_cnt; done_k = -1; op_active = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; addr = ~a; wdata = ~wd; mem_data_sign = ~sg;  // inputs must have been captured
    for (int i = 0; i < exp_L + 2; i++) begin
      @(negedge clk); #1;
      if (cycle_cnt - c0 >= exp_L) break;
    end
    op_active = 1'b0;
    ack_force = 1'b0;
    check("xfer_left", exp_q.size(), 0);
    model_rdata = rdata_new;
    seen_k = done_k;
  endtask

  initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    int k;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    ref_mem[12'h103] = 8'h80;
    ref_mem[12'h300] = 8'hBE;
    ref_mem[12'h301] = 8'hEF;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdata",     rdata,         32'h0);
    check("rst_busy",      busy,          0);
    check("rst_done",      done,          0);
    check("rst_err",       err,           0);
    check("rst_bus_req",   bus.bus_req,   0);
    check("rst_bus_we",    bus.bus_we,    0);
    check("rst_bus_addr",  bus.bus_addr,  32'h0);
    check("rst_bus_wdata", bus.bus_wdata, 0);
    reset = 1'b0;

    // LB / LBU of 0x80 at 0x103
    run_op(1, 0, SIZE_BYTE, 1, 32'h103, 32'h0, 0, 0, 0, k);
    check("lb_done_cycle", k, 2);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    run_op(1, 0, SIZE_BYTE, 0, 32'h103, 32'h0, 0, 0, 0, k);
    check("lbu_rdata", rdata, 32'h0000_0080);

    // SW 0x11223344 to 0x200, big-endian bytes
    run_op(0, 1, SIZE_WORD, 0, 32'h200, 32'h1122_3344, 0, 0, 0, k);
    check("sw_done_cycle", k, 5);
    check("sw_mem0", mem[12'h200], 8'h11);
    check("sw_mem1", mem[12'h201], 8'h22);
    check("sw_mem2", mem[12'h202], 8'h33);
    check("sw_mem3", mem[12'h203], 8'h44);
    check("sw_rdata_kept", rdata, 32'h0000_0080);

    // Check failures; stray ack while bus_req is low must be ignored
    run_op(1, 0, SIZE_HALF, 1, 32'h201, 32'h0, 0, 0, 1, k);
    check("lh_misaligned_done_cycle", k, 1);
    run_op(1, 1, SIZE_WORD, 0, 32'h200, 32'h0, 0, 0, 1, k);
    check("rw_both_done_cycle", k, 1);
    run_op(1, 0, SIZE_ILLEGAL, 0, 32'h200, 32'h0, 0, 0, 0, k);
    run_op(0, 1, SIZE_WORD, 0, 32'h202, 32'hDEAD_BEEF, 0, 0, 0, k);

    // LHU 0xBEEF at 0x300 with three wait cycles on the first byte
    run_op(1, 0, SIZE_HALF, 0, 32'h300, 32'h0, 3, 0, 0, k);
    check("lhu_wait_done_cycle", k, 6);
    check("lhu_rdata", rdata, 32'h0000_BEEF);
    run_op(1, 0, SIZE_HALF, 1, 32'h300, 32'h0, 0, 0, 0, k);
    check("lh_rdata", rdata, 32'hFFFF_BEEF);

    // Byte and half stores, then a word load over them
    run_op(0, 1, SIZE_BYTE, 0, 32'h105, 32'hABCD_EF5A, 0, 0, 0, k);
    run_op(0, 1, SIZE_HALF, 0, 32'h106, 32'h0000_1234, 0, 0, 0, k);
    run_op(1, 0, SIZE_WORD, 1, 32'h104, 32'h0, 0, 0, 0, k);
    check("lw_104_rdata", rdata, 32'h005A_1234);

    // Timeout: no ack at all
    run_op(1, 0, SIZE_WORD, 0, 32'h000, 32'h0, 0, 1, 0, k);
    check("timeout_done_cycle", k, 5);

    // Reset during a word store after two acked bytes
    @(posedge clk); #1;
    first_wait = 0; ack_never = 1'b0;
    mem_read = 1'b0; mem_write = 1'b1; mem_data_size = SIZE_WORD;
    addr = 32'h400; wdata = 32'hCAFE_F00D; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_bus_req", bus.bus_req, 0);
    check("rst_mid_busy",    busy,        0);
    check("rst_mid_done",    done,        0);
    check("rst_mid_rdata",   rdata,       32'h0);
    model_rdata = '0;
    ref_mem[12'h400] = 8'hCA;
    ref_mem[12'h401] = 8'hFE;
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_reset", done, 0);
    end
    check("partial_mem0", mem[12'h400], 8'hCA);
    check("partial_mem1", mem[12'h401], 8'hFE);
    check("partial_mem2", mem[12'h402], 8'h00);

    // Recovery after reset
    run_op(1, 0, SIZE_WORD, 0, 32'h200, 32'h0, 0, 0, 0, k);
    check("lw_after_reset", rdata, 32'h1122_3344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer that executes one data-memory load or store using the control bits produced by the main instruction decoder: read/write strobes, access size, and sign selection. It sits between the datapath's ALU/register outputs and a byte-wide, request/acknowledge data memory. It splits word and halfword accesses into big-endian byte transfers, then reassembles and extends the load result.

## Interface
- ACK_TIMEOUT, 255: maximum wait cycles for mem_ack per byte before the access aborts with err; legal range 1..65535.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle request; sampled only in IDLE.
- mem_read  in  1  load request (decoder MemRead).
- mem_write  in  1  store request (decoder MemWrite).
- mem_data_size  in  2  access size: 11 = word (4 B), 10 = half (2 B), 01 = byte (1 B), 00 = illegal.
- mem_data_sign  in  1  1 = sign-extend load, 0 = zero-extend; ignored for stores.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data; size-aligned in the low bits.
- rdata  out  32  load result; reset value 0; holds until the next accepted load.
- busy  out  1  high from the cycle after start is accepted through the done cycle; reset value 0.
- done  out  1  one-cycle completion pulse; reset value 0.
- err  out  1  valid only with done; 1 = access aborted; reset value 0.
- bus_req  out  1  byte-transfer request; reset value 0.
- bus_we  out  1  1 = write byte; reset value 0.
- bus_addr  out  32  byte address; reset value 0.
- bus_wdata  out  8  write byte; reset value 0.
- bus_rdata  in  8  read byte; valid when bus_ack is high.
- bus_ack  in  1  byte accepted or returned; sampled on an edge while bus_req is high.

## Operation
- States: IDLE, XFER, FINISH.
- IDLE + start: capture addr, wdata, size, sign, and direction. Then check the request:
  - Check failures are: mem_read == mem_write; size 00; half with addr[0]=1; word with addr[1:0]!=0.
  - On any failure: go to FINISH with err=1 and no bus traffic.
  - Otherwise: set byte count n (1, 2, 4), clear the byte index and timeout counter, and go to XFER.
- XFER drives the bus as follows:
  - bus_req=1, bus_addr = captured addr + index, bus_we = direction.
  - bus_wdata = store byte at index, big-endian: the most significant byte of the sized datum goes to the lowest address.
- XFER, per edge:
  - bus_ack=1: latch the byte on loads (shift left 8, OR in bus_rdata), index+1, and reset the timeout counter. If this was the last byte, go to FINISH with err=0.
  - bus_ack=0: increment the timeout counter. When it reaches ACK_TIMEOUT, go to FINISH with err=1, leaving rdata unchanged.
- FINISH: done=1 and busy=1 for one cycle, then return to IDLE.
  - On a successful load, rdata updates in the FINISH cycle: sign- or zero-extended from 8/16 bits per the captured sign; word passes through.
- start is ignored when not in IDLE, and is ignored in the FINISH cycle.
- Stores never modify rdata.

## Timing
- bus_req is registered and drops in the same cycle that FINISH is entered.
- Zero-wait memory (bus_ack tied high), start accepted at edge 0:
  - bus_req is high for cycles 1..n.
  - done is high in cycle n+1.
  - Total latency is n+1 cycles: byte 2, half 3, word 5.
- Each bus wait cycle adds one cycle.
- Check failure: done and err are high in cycle 1, and bus_req never rises.
- bus_ack while bus_req is low is ignored.
- Timeout: err fires after exactly ACK_TIMEOUT consecutive non-ack cycles on one byte.
- Reset mid-access: all outputs return to reset values asynchronously, state goes to IDLE, and no done is issued. A partial store may remain in memory.
- Back-to-back: a start asserted in the cycle after done (state IDLE) is accepted.

## Structure
- Shared package holds:
  - the size encodings (SIZE_BYTE=01, SIZE_HALF=10, SIZE_WORD=11);
  - the state enum;
  - the byte-count function size→n.
- The decoder's opcode constants already define the size/sign mapping; that package is shared with the decoder.
- One sub-module: load_extend (combinational, 32-bit assembled value + size + sign → extended rdata), reused by any future cache fill path.

## Test plan
- LB: memory byte 0x80 at addr 0x103, sign=1, ack tied high → one bus read at 0x103, done in cycle 2, rdata=0xFFFFFF80; the same access with LBU gives 0x00000080.
- SW: wdata 0x11223344 to addr 0x200, ack tied high → writes 0x11@0x200, 0x22@0x201, 0x33@0x202, 0x44@0x203; done in cycle 5, err=0, rdata unchanged.
- LH at addr 0x201 → done and err in cycle 1, zero bus_req cycles; mem_read=mem_write=1 gives the same result.
- LHU 0xBEEF at 0x300, with ack withheld 3 cycles on the first byte → done in cycle 6, rdata=0x0000BEEF.
- ACK_TIMEOUT=4 and ack never asserted → done+err in cycle 5; then assert reset during a word store after 2 acks → bus_req and busy are 0 immediately, and no done follows.
